// File: rtl/tia_horizontal_sync_counter.sv
`default_nettype none
// ============================================================================
// Module      : tia_horizontal_sync_counter
// Description : Six-bit polynomial horizontal sync counter (HSC) for the TIA.
//               Master/slave LFSR driven by the biphase clock enables. It
//               decodes the line-timing events into registered hsync, hblank
//               and line_end. Optional feature macro: TIA_HSC_HMOVE_EN adds
//               the hmove_late port, which extends hblank to LRHB.
// Revision    : 1.0 - initial release
// ============================================================================
module tia_horizontal_sync_counter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       hphi1,
   input  logic       hphi2,
   input  logic       rsynl,
`ifdef TIA_HSC_HMOVE_EN
   input  logic       hmove_late,
`endif
   output logic [5:0] hsc,
   output logic       hsync,
   output logic       hblank,
   output logic       line_end
);

   // Decoded slave values (the index in the sequence from 000000 is in the name).
   // Indices 12 (111100) and 36 (001101) are reserved decodes with no effect.
   localparam logic [5:0] SHB_VAL  = 6'b000000;  // index 0  : start hblank
   localparam logic [5:0] SHS_VAL  = 6'b001111;  // index 4  : set hsync
   localparam logic [5:0] RHS_VAL  = 6'b111011;  // index 8  : reset hsync
   localparam logic [5:0] RHB_VAL  = 6'b001110;  // index 16 : reset hblank
   localparam logic [5:0] LRHB_VAL = 6'b111010;  // index 18 : late reset hblank
   localparam logic [5:0] WRAP_VAL = 6'b001010;  // index 56 : last state

   logic [5:0] master;
   logic [5:0] slave;
   logic [5:0] lfsr_next;
   logic       load_master;
   logic       xfer_slave;
   logic       late_req;
   logic       late_line;

   // Exactly one phase enable must be active for the latches to move.
   assign load_master = hphi1 & ~hphi2;
   assign xfer_slave  = hphi2 & ~hphi1;
   assign hsc         = slave;

`ifdef TIA_HSC_HMOVE_EN
   assign late_req = hmove_late;
`else
   assign late_req = 1'b0;
`endif

   // Feedback: shift left, new LSB is the XNOR of the two top bits.
   always_comb begin
      lfsr_next = {slave[4:0], ~(slave[5] ^ slave[4])};
   end

   // Master/slave counter: master loads on phase 1, slave copies on phase 2,
   // resync clears both and wins over either phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         master <= 6'b000000;
         slave  <= 6'b000000;
      end else if (rsynl) begin
         master <= 6'b000000;
         slave  <= 6'b000000;
      end else if (load_master) begin
         master <= (slave == WRAP_VAL) ? 6'b000000 : lfsr_next;
      end else if (xfer_slave) begin
         slave <= master;
      end
   end

   // Line-timing decodes, evaluated on the value being transferred into the
   // slave so the outputs change on the same edge as hsc.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync     <= 1'b0;
         hblank    <= 1'b1;
         line_end  <= 1'b0;
         late_line <= 1'b0;
      end else if (rsynl) begin
         hsync     <= 1'b0;
         hblank    <= 1'b1;
         line_end  <= 1'b1;
         late_line <= late_req;
      end else begin
         line_end <= 1'b0;
         if (xfer_slave) begin
            case (master)
               SHB_VAL: begin
                  hblank    <= 1'b1;
                  late_line <= late_req;
                  // Only a real wrap (slave leaving a non-zero state) marks a
                  // line end; re-loading zero after reset or resync does not.
                  line_end  <= (slave != SHB_VAL);
               end
               SHS_VAL:  hsync <= 1'b1;
               RHS_VAL:  hsync <= 1'b0;
               RHB_VAL:  if (!late_line) hblank <= 1'b0;
               LRHB_VAL: if (late_line)  hblank <= 1'b0;
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tia_horizontal_sync_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tia_horizontal_sync_counter
// Description : Self-checking bench for tia_horizontal_sync_counter: a vector
//               table for the start of the count, then scoreboarded
//               free-running lines, resync, dual-phase and mid-line reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tia_horizontal_sync_counter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       hphi1 = 1'b0;
   logic       hphi2 = 1'b0;
   logic       rsynl = 1'b0;
   logic       hmove_late = 1'b0;
   logic [5:0] hsc;
   logic       hsync;
   logic       hblank;
   logic       line_end;

   tia_horizontal_sync_counter dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .hphi1      (hphi1),
      .hphi2      (hphi2),
      .rsynl      (rsynl),
`ifdef TIA_HSC_HMOVE_EN
      .hmove_late (hmove_late),
`endif
      .hsc        (hsc),
      .hsync      (hsync),
      .hblank     (hblank),
      .line_end   (line_end)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0] hsc;
      logic       hs;
      logic       hb;
      logic       le;
   } exp_t;

   typedef struct packed {
      logic       p1;
      logic       p2;
      logic       rs;
      logic [5:0] hsc;
      logic       hs;
      logic       hb;
      logic       le;
   } vec_t;

   exp_t sb[$];
   vec_t tab[17];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int ph = 0;

   // reference model state
   logic [5:0] m_master, m_slave;
   logic       m_hs, m_hb, m_le, m_ext;

   // output-level event tracking
   logic prev_hs, prev_hb, prev_le;
   int   le_cyc, hs_cyc, hb_cyc;
   bit   le_valid, hs_valid, hb_valid;

   function automatic logic [5:0] lfsr(input logic [5:0] q);
      return {q[4:0], ~(q[5] ^ q[4])};
   endfunction

   function automatic logic [5:0] idx_val(input int n);
      logic [5:0] q = 6'b000000;
      for (int k = 0; k < n; k++) q = lfsr(q);
      return q;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic hmove_eff();
`ifdef TIA_HSC_HMOVE_EN
      return hmove_late;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_master = 6'b0; m_slave = 6'b0;
      m_hs = 1'b0; m_hb = 1'b1; m_le = 1'b0; m_ext = 1'b0;
      prev_hs = 1'b0; prev_hb = 1'b1; prev_le = 1'b0;
      le_valid = 0; hs_valid = 0; hb_valid = 0;
   endtask

   task automatic model_edge(input logic p1, input logic p2, input logic rs);
      logic [5:0] prev;
      if (rs) begin
         m_master = 6'b0; m_slave = 6'b0;
         m_hs = 1'b0; m_hb = 1'b1; m_le = 1'b1; m_ext = hmove_eff();
      end else begin
         m_le = 1'b0;
         if (p1 && !p2) begin
            m_master = (m_slave == 6'b001010) ? 6'b0 : lfsr(m_slave);
         end else if (p2 && !p1) begin
            prev    = m_slave;
            m_slave = m_master;
            if (m_slave == idx_val(0)) begin
               m_hb  = 1'b1;
               m_ext = hmove_eff();
               if (prev != 6'b0) m_le = 1'b1;
            end
            if (m_slave == idx_val(4))  m_hs = 1'b1;
            if (m_slave == idx_val(8))  m_hs = 1'b0;
            if (m_slave == idx_val(16) && !m_ext) m_hb = 1'b0;
            if (m_slave == idx_val(18) &&  m_ext) m_hb = 1'b0;
         end
      end
   endtask

   // One clock edge: drive at negedge, push expectation, compare after posedge.
   task automatic step(input logic p1, input logic p2, input logic rs,
                       input logic use_tab, input exp_t te);
      exp_t e;
      @(negedge clk);
      hphi1 = p1; hphi2 = p2; rsynl = rs;
      model_edge(p1, p2, rs);
      sb.push_back(use_tab ? te : exp_t'{m_slave, m_hs, m_hb, m_le});
      @(posedge clk);
      #1;
      cyc++;
      e = sb.pop_front();
      chk("hsc", 32'(hsc), 32'(e.hsc));
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("hblank", 32'(hblank), 32'(e.hb));
      chk("line_end", 32'(line_end), 32'(e.le));
      if (line_end && !prev_le) begin
         if (le_valid) chk("line_period", cyc - le_cyc, 228);
         le_cyc = cyc; le_valid = 1;
      end
      if (hsync && !prev_hs) begin hs_cyc = cyc; hs_valid = 1; end
      if (!hsync && prev_hs && hs_valid) chk("hsync_width", cyc - hs_cyc, 16);
      if (hblank && !prev_hb) begin hb_cyc = cyc; hb_valid = 1; end
      if (!hblank && prev_hb && hb_valid)
         chk("hblank_width", cyc - hb_cyc, m_ext ? 72 : 64);
      prev_hs = hsync; prev_hb = hblank; prev_le = line_end;
   endtask

   // Free-running biphase slot: HPHI2, Z, HPHI1, Z. 'both' turns a Z slot
   // into a dual-phase edge.
   task automatic phase_step(input logic rs, input logic both);
      logic p1, p2;
      p1 = (ph == 2);
      p2 = (ph == 0);
      if (both && (ph == 1 || ph == 3)) begin p1 = 1'b1; p2 = 1'b1; end
      step(p1, p2, rs, 1'b0, '0);
      ph = (ph + 1) % 4;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) phase_step(1'b0, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_hsc"}, 32'(hsc), 32'h0);
      chk({tag, "_hsync"}, 32'(hsync), 32'h0);
      chk({tag, "_hblank"}, 32'(hblank), 32'h1);
      chk({tag, "_line_end"}, 32'(line_end), 32'h0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      hphi1 = 1'b0; hphi2 = 1'b0; rsynl = 1'b0;
      #1 check_reset_values("async_reset");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      ph = 0;
   endtask

   initial begin
      int i;
      // p1 p2 rs   hsc        hs    hb    le
      tab[0]  = '{1'b0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0};
      tab[1]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0};
      tab[2]  = '{1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0};
      tab[3]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0};
      tab[4]  = '{1'b0, 1'b1, 1'b0, 6'b000001, 1'b0, 1'b1, 1'b0};
      tab[5]  = '{1'b0, 1'b0, 1'b0, 6'b000001, 1'b0, 1'b1, 1'b0};
      tab[6]  = '{1'b1, 1'b0, 1'b0, 6'b000001, 1'b0, 1'b1, 1'b0};
      tab[7]  = '{1'b1, 1'b1, 1'b0, 6'b000001, 1'b0, 1'b1, 1'b0};
      tab[8]  = '{1'b0, 1'b1, 1'b0, 6'b000011, 1'b0, 1'b1, 1'b0};
      tab[9]  = '{1'b0, 1'b0, 1'b0, 6'b000011, 1'b0, 1'b1, 1'b0};
      tab[10] = '{1'b0, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b1, 1'b1};
      tab[11] = '{1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0};
      tab[12] = '{1'b0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0};
      tab[13] = '{1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0};
      tab[14] = '{1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0};
      tab[15] = '{1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0};
      tab[16] = '{1'b0, 1'b1, 1'b0, 6'b000001, 1'b0, 1'b1, 1'b0};

      // Asynchronous reset before any clock edge.
      #1 reset_n = 1'b0;
      #2 check_reset_values("reset");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;

      // Vector table: first states, dual-phase hold, resync, no spurious line_end.
      for (i = 0; i < 17; i++)
         step(tab[i].p1, tab[i].p2, tab[i].rs, 1'b1,
              exp_t'{tab[i].hsc, tab[i].hs, tab[i].hb, tab[i].le});

      // Three free-running lines from reset.
      pulse_reset();
      run(700);

`ifdef TIA_HSC_HMOVE_EN
      hmove_late = 1'b1;
      run(228);
      hmove_late = 1'b0;
      run(228);
`endif

      // Resync while the slave sits at index 30, on a phase-2 slot.
      i = 0;
      while (i < 400 && !(m_slave == idx_val(30) && ph == 0)) begin
         phase_step(1'b0, 1'b0);
         i++;
      end
      chk("resync_search", 32'(m_slave == idx_val(30) && ph == 0), 32'h1);
      le_valid = 0;
      phase_step(1'b1, 1'b0);
      chk("resync_line_end", 32'(line_end), 32'h1);
      // Dual-phase edges in Z slots during the following line must not disturb it.
      run(41);
      phase_step(1'b0, 1'b1);
      run(200);
      phase_step(1'b0, 1'b1);
      run(230);

      // Reset asserted mid-line at index 6 while hsync is high.
      i = 0;
      while (i < 400 && m_slave != idx_val(6)) begin
         phase_step(1'b0, 1'b0);
         i++;
      end
      chk("idx6_search", 32'(m_slave == idx_val(6)), 32'h1);
      chk("hsync_before_reset", 32'(hsync), 32'h1);
      pulse_reset();
      run(240);

      if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
